// File: rtl/uart_rx_os.sv
// uart_rx_os: 16x oversampling UART receiver fed by the baud counter's
// max_tick strobe. Samples DBIT data bits LSB first at their midpoints and
// checks the stop bit. Optional parity bit when UART_RX_PARITY_EN is defined.
// Ports:
//   clk          system clock
//   reset        asynchronous active-high reset
//   s_tick       one-clk 16x-baud oversampling strobe
//   rx           serial line, idle high, asynchronous
//   dout         last received word
//   rx_done_tick one-clk pulse when a new word is committed to dout
//   frame_err    stop bit sampled low for the word on dout
//   parity_err   parity mismatch for the word on dout (0 without parity)
module uart_rx_os #(
   parameter int DBIT    = 8,
   parameter int SB_TICK = 16,
   parameter bit PAR_ODD = 1'b0
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            s_tick,
   input  logic            rx,
   output logic [DBIT-1:0] dout,
   output logic            rx_done_tick,
   output logic            frame_err,
   output logic            parity_err
);

   localparam int NW = $clog2(DBIT);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef UART_RX_PARITY_EN
      PARITY,
`endif
      STOP
   } state_t;

   state_t          state_q, state_d;
   logic            sync1_q, sync2_q;
   logic            rxs;
   logic [4:0]      s_q, s_d;
   logic [NW-1:0]   n_q, n_d;
   logic [DBIT-1:0] b_q, b_d;
   logic            stop_q, stop_d;
   logic [DBIT-1:0] dout_q, dout_d;
   logic            done_q, done_d;
   logic            ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
   logic            p_q, p_d;
   logic            mis_q, mis_d;
   logic            perr_q, perr_d;
`endif

   assign rxs = sync2_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         state_q <= IDLE;
         s_q     <= '0;
         n_q     <= '0;
         b_q     <= '0;
         stop_q  <= 1'b0;
         dout_q  <= '0;
         done_q  <= 1'b0;
         ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
         p_q     <= 1'b0;
         mis_q   <= 1'b0;
         perr_q  <= 1'b0;
`endif
      end else begin
         sync1_q <= rx;
         sync2_q <= sync1_q;
         state_q <= state_d;
         s_q     <= s_d;
         n_q     <= n_d;
         b_q     <= b_d;
         stop_q  <= stop_d;
         dout_q  <= dout_d;
         done_q  <= done_d;
         ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
         p_q     <= p_d;
         mis_q   <= mis_d;
         perr_q  <= perr_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      s_d     = s_q;
      n_d     = n_q;
      b_d     = b_q;
      stop_d  = stop_q;
      dout_d  = dout_q;
      done_d  = 1'b0;
      ferr_d  = ferr_q;
`ifdef UART_RX_PARITY_EN
      p_d     = p_q;
      mis_d   = mis_q;
      perr_d  = perr_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (!rxs) begin
               state_d = START;
               s_d     = '0;
            end
         end
         START: begin
            if (s_tick) begin
               if (s_q == 5'd7) begin
                  if (!rxs) begin
                     state_d = DATA;
                     s_d     = '0;
                     n_d     = '0;
`ifdef UART_RX_PARITY_EN
                     p_d     = PAR_ODD;
`endif
                  end else begin
                     state_d = IDLE;
                  end
               end else begin
                  s_d = s_q + 5'd1;
               end
            end
         end
         DATA: begin
            if (s_tick) begin
               if (s_q == 5'd15) begin
                  s_d = '0;
                  b_d = {rxs, b_q[DBIT-1:1]};
`ifdef UART_RX_PARITY_EN
                  p_d = p_q ^ rxs;
`endif
                  if (n_q == NW'(DBIT-1)) begin
`ifdef UART_RX_PARITY_EN
                     state_d = PARITY;
`else
                     state_d = STOP;
`endif
                  end else begin
                     n_d = n_q + 1'b1;
                  end
               end else begin
                  s_d = s_q + 5'd1;
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         PARITY: begin
            if (s_tick) begin
               if (s_q == 5'd15) begin
                  mis_d   = p_q ^ rxs;
                  s_d     = '0;
                  state_d = STOP;
               end else begin
                  s_d = s_q + 5'd1;
               end
            end
         end
`endif
         STOP: begin
            if (s_tick) begin
               // with SB_TICK=16 the sample and the exit share one tick
               if (s_q == 5'd15)
                  stop_d = rxs;
               if (s_q == 5'(SB_TICK-1)) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
                  dout_d  = b_q;
                  ferr_d  = !stop_d;
`ifdef UART_RX_PARITY_EN
                  perr_d  = mis_q;
`endif
               end else begin
                  s_d = s_q + 5'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign dout         = dout_q;
   assign rx_done_tick = done_q;
   assign frame_err    = ferr_q;
`ifdef UART_RX_PARITY_EN
   assign parity_err   = perr_q;
`else
   // PAR_ODD has no effect in this build
   assign parity_err   = 1'b0 & PAR_ODD;
`endif

endmodule

// File: tb/tb_uart_rx_os.sv
// tb_uart_rx_os: scoreboard bench for uart_rx_os.
// Stimulus queues expected words; a forked monitor pops on rx_done_tick.
module tb_uart_rx_os;

   localparam int DBIT    = 8;
   localparam int SB_TICK = 16;
   localparam bit PAR_ODD = 1'b0;
`ifdef UART_RX_PARITY_EN
   localparam bit HAS_PAR = 1'b1;
`else
   localparam bit HAS_PAR = 1'b0;
`endif
   localparam int FRAME_TICKS = 8 + 16*DBIT + (HAS_PAR ? 16 : 0) + SB_TICK;
   localparam int LAT_LO = 4*FRAME_TICKS;
   localparam int LAT_HI = 4*FRAME_TICKS + 3;

   logic            clk = 1'b0;
   logic            reset;
   logic            s_tick = 1'b0;
   logic            rx;
   logic [DBIT-1:0] dout;
   logic            rx_done_tick;
   logic            frame_err;
   logic            parity_err;

   typedef struct {
      logic [DBIT-1:0] data;
      logic            ferr;
      logic            perr;
      int              start;
   } exp_t;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   pulses = 0;
   int   cyc = 0;
   int   tcnt = 0;
   bit   fin = 1'b0;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc    <= cyc + 1;
      tcnt   <= (tcnt == 3) ? 0 : tcnt + 1;
      s_tick <= (tcnt == 2);
   end

   uart_rx_os #(
      .DBIT(DBIT), .SB_TICK(SB_TICK), .PAR_ODD(PAR_ODD)
   ) dut (
      .clk(clk),
      .reset(reset),
      .s_tick(s_tick),
      .rx(rx),
      .dout(dout),
      .rx_done_tick(rx_done_tick),
      .frame_err(frame_err),
      .parity_err(parity_err)
   );

   task automatic check(input string nm, input logic [63:0] act,
                        input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // returns #1 after the edge that consumed the n-th tick
   task automatic wait_ticks(input int n);
      repeat (n) begin
         @(posedge clk);
         while (!s_tick) @(posedge clk);
      end
      #1;
   endtask

   task automatic send_frame(input logic [DBIT-1:0] d, input bit good,
                             input bit pb, input int gap);
      exp_t e;
      e.data  = d;
      e.ferr  = !good;
      e.perr  = HAS_PAR ? (((^d) ^ pb) != PAR_ODD) : 1'b0;
      e.start = cyc;
      q.push_back(e);
      rx = 1'b0;
      wait_ticks(16);
      for (int i = 0; i < DBIT; i++) begin
         rx = d[i];
         wait_ticks(16);
      end
      if (HAS_PAR) begin
         rx = pb;
         wait_ticks(16);
      end
      if (good) begin
         rx = 1'b1;
         wait_ticks(16);
      end else begin
         // low past the stop sample, high before a false start matures
         rx = 1'b0;
         wait_ticks(12);
         rx = 1'b1;
         wait_ticks(4);
      end
      if (gap > 0) wait_ticks(gap);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_dout"}, 64'(dout), 64'h0);
      check({tag, "_done"}, 64'(rx_done_tick), 64'h0);
      check({tag, "_ferr"}, 64'(frame_err), 64'h0);
      check({tag, "_perr"}, 64'(parity_err), 64'h0);
   endtask

   initial begin
      reset = 1'b1;
      rx    = 1'b1;
      fork
         begin : monitor
            exp_t e;
            bit   prev;
            int   lat;
            prev = 1'b0;
            while (!fin) begin
               @(negedge clk);
               if (reset) begin
                  prev = 1'b0;
               end else begin
                  if (rx_done_tick) begin
                     pulses++;
                     if (q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL spurious_done: got pulse dout=%0h expected none",
                                 dout);
                     end else begin
                        e = q.pop_front();
                        lat = cyc - e.start;
                        check("dout", 64'(dout), 64'(e.data));
                        check("frame_err", 64'(frame_err), 64'(e.ferr));
                        check("parity_err", 64'(parity_err), 64'(e.perr));
                        n_cmp++;
                        if (lat < LAT_LO || lat > LAT_HI) begin
                           n_bad++;
                           $display("FAIL latency: got %0d clk expected %0d..%0d",
                                    lat, LAT_LO, LAT_HI);
                        end
                     end
                  end
                  if (rx_done_tick && prev) begin
                     n_cmp++;
                     n_bad++;
                     $display("FAIL done_width: got 2+ clk expected 1 clk");
                  end
                  prev = rx_done_tick;
               end
            end
         end
         begin : stim
            int p0;
            repeat (5) @(posedge clk);
            #1;
            check_reset_vals("rst0");
            reset = 1'b0;
            repeat (1000) @(posedge clk);
            #1;
            check("idle_pulses", 64'(pulses), 64'h0);
            reset = 1'b1;
            #2;
            check_reset_vals("rst_idle");
            repeat (3) @(posedge clk);
            #1;
            reset = 1'b0;
            wait_ticks(4);

            p0 = pulses;
            send_frame(8'hA5, 1'b1, 1'b0, 0);
            send_frame(8'h00, 1'b1, 1'b0, 0);
            send_frame(8'hFF, 1'b1, 1'b0, 8);
            check("b2b_pulses", 64'(pulses - p0), 64'd3);

            p0 = pulses;
            rx = 1'b0;
            wait_ticks(4);
            rx = 1'b1;
            wait_ticks(24);
            check("glitch_pulses", 64'(pulses - p0), 64'd0);
            send_frame(8'h3C, 1'b1, 1'b0, 4);

            send_frame(8'h3C, 1'b0, 1'b0, 4);
            send_frame(8'h81, 1'b1, 1'b0, 4);

            p0 = pulses;
            rx = 1'b0;
            wait_ticks(16);
            for (int i = 0; i < 3; i++) begin
               rx = 1'(8'h77 >> i);
               wait_ticks(16);
            end
            reset = 1'b1;
            #2;
            check_reset_vals("rst_mid");
            rx = 1'b1;
            repeat (3) @(posedge clk);
            #1;
            reset = 1'b0;
            wait_ticks(200);
            check("abort_pulses", 64'(pulses - p0), 64'd0);
            send_frame(8'h5A, 1'b1, 1'b0, 4);

`ifdef UART_RX_PARITY_EN
            send_frame(8'h0F, 1'b1, 1'b0, 4);
            send_frame(8'h0F, 1'b1, 1'b1, 4);
`endif

            for (int k = 0; k < 12; k++) begin
               send_frame(8'($urandom), $urandom_range(0, 3) != 0,
                          1'($urandom_range(0, 1)), $urandom_range(0, 10));
            end

            for (int i = 0; i < 2000 && q.size() != 0; i++)
               @(posedge clk);
            check("drain", 64'(q.size()), 64'h0);
            repeat (4) @(posedge clk);
            fin = 1'b1;
         end
      join
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
